ypbpr_sync_insert: RTL
======================

Name: ypbpr_sync_insert

Overview:
Stage directly downstream of the 6-bit RGB->YPbPr converter. Normalises hsync and vsync polarity, then generates a blanking window. During sync and blanking it forces Y to sync or black level and Pb/Pr to midscale. It rescales active Y above a black pedestal, so the 6-bit outputs feed the component DAC as sync-on-Y video. A 2-cycle pipeline keeps the video and sync signals aligned.

Parameters:
BLACK_LEVEL, 18, Y code for black; active Y is scaled into BLACK_LEVEL..63; range 1..32.
BLANK_BACK, 16, number of pixel_in-qualified clocks after the end of hsync that stay blanked (back porch); range 0..255.
POL_CNT_W, 12, width of the polarity-measurement counters.

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
ena  in  1  1 = YPbPr processing; 0 = transparent passthrough
y_in  in  6  luma from converter (unsigned, 0 = black)
pb_in  in  6  Pb, offset binary (32 = zero)
pr_in  in  6  Pr, offset binary (32 = zero)
hs_in  in  1  hsync, either polarity
vs_in  in  1  vsync, either polarity
cs_in  in  1  composite sync, same polarity as hs_in
pixel_in  in  1  pixel-clock enable
y_out  out  6  luma with embedded sync
pb_out  out  6  blanked Pb
pr_out  out  6  blanked Pr
hs_out  out  1  hsync, normalised active-low
vs_out  out  1  vsync, normalised active-low
cs_out  out  1  csync, normalised active-low
pixel_out  out  1  pixel_in delayed 2 clocks

Behaviour:
- Reset (synchronous): y_out=0, pb_out=pr_out=32, hs_out=vs_out=cs_out=1, pixel_out=0. Polarity bits=0 (active-low), counters=0, blank counter=0.
- Latency: every output is exactly 2 clocks after its input, regardless of ena. Sync/pixel delays run every clock.
- Hsync polarity detection:
  - hi_cnt clears on the hs_in rising edge and counts clocks while hs_in=1.
  - lo_cnt clears on the hs_in falling edge and counts clocks while hs_in=0.
  - Both counters saturate at all-ones. Edges are detected against a 1-clock delayed hs_in.
  - On each rising edge, before the clear: hi_cnt<lo_cnt sets hs_pol=1 (active-high); hi_cnt>lo_cnt sets hs_pol=0; equal leaves it unchanged.
- Vsync polarity detection: same scheme, but the counters count hs_in rising edges (lines) instead of clocks. The result is vs_pol.
- Normalisation: hs_n = hs_in ^ hs_pol, vs_n = vs_in ^ vs_pol, cs_n = cs_in ^ hs_pol.
- Blank counter:
  - Loads BLANK_BACK on every clock with hs_n=0.
  - Otherwise decrements on pixel_in=1 while nonzero.
  - blank = (hs_n=0) | (vs_n=0) | (blank counter != 0).
- Stage 1 (when ena=1): product = y_in * (64-BLACK_LEVEL), 12 bits. Register blank, cs_n, pb_in and pr_in.
- Stage 2 (when ena=1):
  - cs_n=0: y_out = 0.
  - Otherwise, blank: y_out = BLACK_LEVEL.
  - Otherwise: y_out = BLACK_LEVEL + product[11:6], which never exceeds 63.
  - pb_out/pr_out = 32 when blank or cs_n=0; otherwise the delayed inputs.
- ena=0: y/pb/pr pass through unchanged with 2-clock latency. hs/vs/cs_out are the raw inputs delayed, not normalised. Polarity detection keeps running.
- Switching ena mid-line: takes effect on the stage-1 register of that clock. No glitch suppression is required.
- Reset mid-line: polarity is re-learned. The first valid hs_pol appears at the second hsync rising edge after reset.

Optional Feature:
YPBPR_POLDETECT_EN
- Defined: automatic polarity detection as described above.
- Undefined: the detection counters are not built, hs_pol=vs_pol=0 is constant, and inputs are assumed active-low. All other behaviour is identical.

Test Plan:
1. Active-low hsync, 96 clocks low / 704 clocks high, ena=1 -> after 2 lines hs_pol=0; hs_out tracks hs_in delayed 2 clocks.
2. Inverted (active-high) hsync and vsync, same timing -> hs_pol=vs_pol=1 after 2 lines/frames; hs_out and vs_out are active-low.
3. Active video with y_in=63, pb_in=10, pr_in=50, BLACK_LEVEL=18 -> y_out=63, pb_out=10, pr_out=50, two clocks later.
4. y_in=0 in active video -> y_out=18. During cs_n=0 -> y_out=0, pb_out=pr_out=32.
5. hsync ends, pixel_in toggling every 2nd clock, BLANK_BACK=16 -> y_out held at 18 for 16 pixel_in pulses (32 clocks) after hsync, then tracks video.
6. ena=0, y_in=5, pb_in=7, pr_in=9, hs_in active-high -> outputs 5/7/9 after 2 clocks; hs_out is not inverted. Asserting reset -> y_out=0, pb_out=pr_out=32 on the next clock.

Source files
------------

// File: rtl/ypbpr_sync_insert.sv
// Sync/blank insertion ahead of a 6-bit component DAC (sync-on-Y), 2-clock pipeline.
// Define YPBPR_POLDETECT_EN to learn hsync/vsync polarity; otherwise inputs are taken as active-low.
module ypbpr_sync_insert #(
  parameter int unsigned BLACK_LEVEL = 18,
  parameter int unsigned BLANK_BACK  = 16,
  parameter int unsigned POL_CNT_W   = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic [5:0] y_in,
  input  logic [5:0] pb_in,
  input  logic [5:0] pr_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       cs_in,
  input  logic       pixel_in,
  output logic [5:0] y_out,
  output logic [5:0] pb_out,
  output logic [5:0] pr_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       cs_out,
  output logic       pixel_out
);

  localparam logic [5:0] BlackLvl  = 6'(BLACK_LEVEL);
  localparam logic [5:0] Scale     = 6'(64 - BLACK_LEVEL);
  localparam logic [7:0] BlankBack = 8'(BLANK_BACK);
  localparam logic [5:0] MidScale  = 6'd32;

  logic hs_pol, vs_pol;

`ifdef YPBPR_POLDETECT_EN
  logic                 hs_d_q, vs_d_q;
  logic                 hs_rise, hs_fall, vs_rise, vs_fall;
  logic [POL_CNT_W-1:0] hhi_q, hlo_q, vhi_q, vlo_q;
  logic                 hs_pol_q, vs_pol_q;

  function automatic logic [POL_CNT_W-1:0] sat_inc(input logic [POL_CNT_W-1:0] v);
    return (v == '1) ? v : v + {{(POL_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign hs_rise = hs_in & ~hs_d_q;
  assign hs_fall = ~hs_in & hs_d_q;
  assign vs_rise = vs_in & ~vs_d_q;
  assign vs_fall = ~vs_in & vs_d_q;

  // The shorter of the two phases is the sync pulse; vertical phases are measured in lines.
  always_ff @(posedge clk) begin
    if (reset) begin
      hs_d_q   <= 1'b0;
      vs_d_q   <= 1'b0;
      hhi_q    <= '0;
      hlo_q    <= '0;
      vhi_q    <= '0;
      vlo_q    <= '0;
      hs_pol_q <= 1'b0;
      vs_pol_q <= 1'b0;
    end else begin
      hs_d_q <= hs_in;
      vs_d_q <= vs_in;
      if (hs_rise) begin
        if (hhi_q < hlo_q) hs_pol_q <= 1'b1;
        else if (hhi_q > hlo_q) hs_pol_q <= 1'b0;
        hhi_q <= '0;
      end else if (hs_in) begin
        hhi_q <= sat_inc(hhi_q);
      end
      if (hs_fall) hlo_q <= '0;
      else if (!hs_in) hlo_q <= sat_inc(hlo_q);
      if (vs_rise) begin
        if (vhi_q < vlo_q) vs_pol_q <= 1'b1;
        else if (vhi_q > vlo_q) vs_pol_q <= 1'b0;
        vhi_q <= '0;
      end else if (vs_in && hs_rise) begin
        vhi_q <= sat_inc(vhi_q);
      end
      if (vs_fall) vlo_q <= '0;
      else if (!vs_in && hs_rise) vlo_q <= sat_inc(vlo_q);
    end
  end

  assign hs_pol = hs_pol_q;
  assign vs_pol = vs_pol_q;
`else
  logic [POL_CNT_W-1:0] unused_pol_cnt;
  assign unused_pol_cnt = '0;
  assign hs_pol = 1'b0;
  assign vs_pol = 1'b0;
`endif

  logic       hs_n, vs_n, cs_n, blank;
  logic [7:0] blank_cnt_q;

  assign hs_n  = hs_in ^ hs_pol;
  assign vs_n  = vs_in ^ vs_pol;
  assign cs_n  = cs_in ^ hs_pol;
  assign blank = ~hs_n | ~vs_n | (blank_cnt_q != 8'd0);

  // Back porch is counted in pixels, reloaded for as long as hsync is active.
  always_ff @(posedge clk) begin
    if (reset) begin
      blank_cnt_q <= 8'd0;
    end else if (!hs_n) begin
      blank_cnt_q <= BlankBack;
    end else if (pixel_in && blank_cnt_q != 8'd0) begin
      blank_cnt_q <= blank_cnt_q - 8'd1;
    end
  end

  logic [11:0] prod;
  assign prod = {6'd0, y_in} * {6'd0, Scale};

  logic        ena_s1_q, blank_s1_q, csn_s1_q, hs_s1_q, vs_s1_q, cs_s1_q, pix_s1_q;
  logic [11:0] y_s1_q;
  logic [5:0]  pb_s1_q, pr_s1_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      ena_s1_q   <= 1'b0;
      y_s1_q     <= 12'd0;
      pb_s1_q    <= MidScale;
      pr_s1_q    <= MidScale;
      blank_s1_q <= 1'b0;
      csn_s1_q   <= 1'b1;
      hs_s1_q    <= 1'b1;
      vs_s1_q    <= 1'b1;
      cs_s1_q    <= 1'b1;
      pix_s1_q   <= 1'b0;
    end else begin
      ena_s1_q   <= ena;
      y_s1_q     <= ena ? prod : {6'd0, y_in};
      pb_s1_q    <= pb_in;
      pr_s1_q    <= pr_in;
      blank_s1_q <= blank;
      csn_s1_q   <= cs_n;
      hs_s1_q    <= ena ? hs_n : hs_in;
      vs_s1_q    <= ena ? vs_n : vs_in;
      cs_s1_q    <= ena ? cs_n : cs_in;
      pix_s1_q   <= pixel_in;
    end
  end

  logic [5:0] y_d, pb_d, pr_d;

  always_comb begin
    y_d  = y_s1_q[5:0];
    pb_d = pb_s1_q;
    pr_d = pr_s1_q;
    if (ena_s1_q) begin
      if (!csn_s1_q)       y_d = 6'd0;
      else if (blank_s1_q) y_d = BlackLvl;
      else                 y_d = BlackLvl + y_s1_q[11:6];
      if (blank_s1_q || !csn_s1_q) begin
        pb_d = MidScale;
        pr_d = MidScale;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_out     <= 6'd0;
      pb_out    <= MidScale;
      pr_out    <= MidScale;
      hs_out    <= 1'b1;
      vs_out    <= 1'b1;
      cs_out    <= 1'b1;
      pixel_out <= 1'b0;
    end else begin
      y_out     <= y_d;
      pb_out    <= pb_d;
      pr_out    <= pr_d;
      hs_out    <= hs_s1_q;
      vs_out    <= vs_s1_q;
      cs_out    <= cs_s1_q;
      pixel_out <= pix_s1_q;
    end
  end

endmodule
